// File: rtl/vga_timing_pkg.sv
// Shared 640x480 raster timing constants for the sync generator, the RGB stage and the image ROM.
// Also holds the window-membership helper used by the decoders.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 46;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 18;

    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 32;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 11;

    localparam int H_TOTAL = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
    localparam int V_TOTAL = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;
    localparam int H_START = DEF_H_SYNC + DEF_H_BP;
    localparam int V_START = DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_IMG_X0   = 256;
    localparam int DEF_IMG_Y0   = 160;
    localparam int IMAGE_WIDTH  = 128;
    localparam int IMAGE_HEIGHT = 160;
    localparam int IMAGE_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;

    // Half-open membership test: lo <= value < hi.
    function automatic logic in_range(input logic [CNT_W-1:0] value, input int lo, input int hi);
        return (int'(value) >= lo) && (int'(value) < hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter with registered active-low sync.
// The next-state count and its active-region decode are exported so the top can register flags aligned with count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP
) (
    input  logic             i_clk,
    input  logic             i_arst,
    input  logic             i_enable,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_count,
    output logic [CNT_W-1:0] o_count_next,
    output logic             o_sync_n,
    output logic             o_active,
    output logic             o_wrap
);

    localparam int TOTAL = SYNC + BP + ACTIVE + FP;
    localparam int START = SYNC + BP;

    logic [CNT_W-1:0] r_count;
    logic             r_sync_n;
    logic [CNT_W-1:0] w_next;
    logic             w_wrap;

    assign w_wrap = (int'(r_count) == TOTAL - 1);

    // Clear wins over enable; with neither, the count holds (used for the first enabled cycle).
    always_comb begin
        w_next = r_count;
        if (i_clear) begin
            w_next = '0;
        end else if (i_enable) begin
            w_next = w_wrap ? '0 : r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_count  <= '0;
            r_sync_n <= 1'b1;
        end else begin
            r_count  <= w_next;
            r_sync_n <= i_clear ? 1'b1 : !in_range(w_next, 0, SYNC);
        end
    end

    assign o_count      = r_count;
    assign o_count_next = w_next;
    assign o_sync_n     = r_sync_n;
    assign o_active     = in_range(w_next, START, START + ACTIVE);
    assign o_wrap       = w_wrap;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: counters, syncs, region flags and the frame-synchronous update strobe.
// Every flag is registered from next-state counts so it lines up with the o_hcnt/o_vcnt it describes.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int IMG_X0   = DEF_IMG_X0,
    parameter int IMG_Y0   = DEF_IMG_Y0,
    parameter int IMG_W    = IMAGE_WIDTH,
    parameter int IMG_H    = IMAGE_HEIGHT
) (
    input  logic        i_clk_27,
    input  logic        i_arst,
    input  logic        i_on,
    input  logic        i_update_req,
    output logic [9:0]  o_hcnt,
    output logic [9:0]  o_vcnt,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_blank,
    output logic        o_active_area,
    output logic        o_image_active,
    output logic        o_new_data,
    output logic        o_frame_start
);

    localparam int H_START_P = H_SYNC + H_BP;
    localparam int V_START_P = V_SYNC + V_BP;
    localparam int IMG_H_LO  = H_START_P + IMG_X0;
    localparam int IMG_V_LO  = V_START_P + IMG_Y0;
    localparam int SVC_LINE  = V_START_P + V_ACTIVE;

    logic             r_run;
    logic             r_pending;
    logic             r_blank;
    logic             r_active_area;
    logic             r_image_active;
    logic             r_new_data;
    logic             r_frame_start;

    logic             w_clear;
    logic             w_h_enable;
    logic             w_v_enable;
    logic [CNT_W-1:0] w_h_next;
    logic [CNT_W-1:0] w_v_next;
    logic             w_h_active;
    logic             w_v_active;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_img;
    logic             w_frame;
    logic             w_service;

    // r_run lags i_on by one cycle, so the first enabled cycle holds at 0,0 instead of advancing.
    assign w_clear    = !i_on;
    assign w_h_enable = r_run;
    assign w_v_enable = r_run && w_h_wrap;

    vga_axis_counter #(
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP)
    ) u_h_axis (
        .i_clk        (i_clk_27),
        .i_arst       (i_arst),
        .i_enable     (w_h_enable),
        .i_clear      (w_clear),
        .o_count      (o_hcnt),
        .o_count_next (w_h_next),
        .o_sync_n     (o_hsync),
        .o_active     (w_h_active),
        .o_wrap       (w_h_wrap)
    );

    vga_axis_counter #(
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP)
    ) u_v_axis (
        .i_clk        (i_clk_27),
        .i_arst       (i_arst),
        .i_enable     (w_v_enable),
        .i_clear      (w_clear),
        .o_count      (o_vcnt),
        .o_count_next (w_v_next),
        .o_sync_n     (o_vsync),
        .o_active     (w_v_active),
        .o_wrap       (w_v_wrap)
    );

    assign w_img = in_range(w_h_next, IMG_H_LO, IMG_H_LO + IMG_W)
                && in_range(w_v_next, IMG_V_LO, IMG_V_LO + IMG_H);

    // Next position is 0,0 either on a start-up cycle or when both axes wrap together.
    assign w_frame = !r_run || (w_h_wrap && w_v_wrap);

    // Service point: first pixel of the vertical front porch.
    assign w_service = i_on && (w_h_next == '0) && (int'(w_v_next) == SVC_LINE);

    always_ff @(posedge i_clk_27 or posedge i_arst) begin
        if (i_arst) begin
            r_run          <= 1'b0;
            r_pending      <= 1'b0;
            r_blank        <= 1'b0;
            r_active_area  <= 1'b0;
            r_image_active <= 1'b0;
            r_new_data     <= 1'b0;
            r_frame_start  <= 1'b0;
        end else begin
            r_run          <= i_on;
            r_pending      <= w_service ? 1'b0 : (r_pending || i_update_req);
            r_new_data     <= w_service && (r_pending || i_update_req);
            r_blank        <= i_on && w_h_active && w_v_active;
            r_active_area  <= i_on && w_h_active && w_v_active;
            r_image_active <= i_on && w_img;
            r_frame_start  <= i_on && w_frame;
        end
    end

    assign o_blank        = r_blank;
    assign o_active_area  = r_active_area;
    assign o_image_active = r_image_active;
    assign o_new_data     = r_new_data;
    assign o_frame_start  = r_frame_start;

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA raster timing generator for the 640x480 BAM display path. It produces the horizontal and vertical pixel counters, the active-low sync pulses, and the region flags that the downstream RGB stage consumes: blank, text active area, image window and new-data strobe. It also carries the frame-synchronous update handshake, so that screen content changes only at the start of vertical blanking and never mid-frame.

## Interface
Parameters:
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 46, horizontal back porch; active columns start at H_SYNC+H_BP = 142
- H_ACTIVE, 640, visible columns
- H_FP, 18, front porch; H_TOTAL = 800
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 32, vertical back porch; active rows start at 34
- V_ACTIVE, 480, visible rows
- V_FP, 11, front porch; V_TOTAL = 525
- IMG_X0, 256, image window left edge, relative to the first active column
- IMG_Y0, 160, image window top edge, relative to the first active row
- IMG_W, 128, image window width
- IMG_H, 160, image window height

Ports:
- i_clk_27  in  1  pixel clock; the single clock of the block
- i_arst  in  1  asynchronous, active-high reset
- i_on  in  1  display enable
- i_update_req  in  1  single-cycle request to refresh screen content
- o_hcnt  out  10  horizontal counter, 0..H_TOTAL-1
- o_vcnt  out  10  vertical counter, 0..V_TOTAL-1
- o_hsync  out  1  active-low horizontal sync
- o_vsync  out  1  active-low vertical sync
- o_blank  out  1  1 = visible pixel (inside active H and active V)
- o_active_area  out  1  text region; equals o_blank
- o_image_active  out  1  pixel lies inside the image window
- o_new_data  out  1  one-cycle content-update strobe
- o_frame_start  out  1  one-cycle pulse at hcnt=0, vcnt=0

## Operation
- Horizontal counter:
  - Increments every cycle.
  - Wraps from H_TOTAL-1 to 0.
- Vertical counter:
  - Increments when the horizontal counter wraps.
  - Wraps from V_TOTAL-1 to 0.
- o_hsync = 0 iff hcnt < H_SYNC.
- o_vsync = 0 iff vcnt < V_SYNC.
- o_blank = 1 iff 142 <= hcnt <= 781 and 34 <= vcnt <= 513 (values at default parameters).
- o_image_active = 1 iff both hold:
  - hcnt is in [142+IMG_X0, 142+IMG_X0+IMG_W)
  - vcnt is in [34+IMG_Y0, 34+IMG_Y0+IMG_H)
  - This gives exactly IMG_W*IMG_H = 20480 asserted cycles per frame, in raster order.
- Update handshake:
  - A 1-bit `pending` register sets on i_update_req.
  - The request is serviced at the start of vertical front porch, i.e. the cycle in which hcnt=0 and vcnt=34+V_ACTIVE (514).
  - At that point o_new_data pulses for exactly one cycle and `pending` clears.
  - If i_update_req coincides with the service cycle, it is absorbed by that service and `pending` ends at 0.
  - Multiple requests within one frame produce a single o_new_data pulse.
- While i_on=0:
  - Counters are synchronously held at 0.
  - hsync and vsync are held at 1.
  - All flags and strobes are held at 0.
  - `pending` is retained, and requests are still latched.
- On i_on rising, counting starts from 0,0. The first o_frame_start occurs in the first enabled cycle.

## Timing
- All outputs are registers. There are no combinational paths from inputs to outputs.
- Flags are decoded from next-state counter values, so that every flag is aligned in the same cycle with the o_hcnt/o_vcnt values it describes.
- Reset (i_arst=1, asynchronous) sets:
  - o_hcnt=0, o_vcnt=0
  - o_hsync=1, o_vsync=1
  - o_blank=0, o_active_area=0, o_image_active=0
  - o_new_data=0, o_frame_start=0
  - pending=0
- Reset mid-frame: the outputs go to the values above immediately. After release, the first enabled cycle shows counters 0,0 with o_frame_start=1.
- i_update_req to o_new_data latency: from 1 cycle up to one full frame (420000 cycles), depending on raster position.
- Frame period: H_TOTAL*V_TOTAL = 420000 cycles; line period: 800 cycles.

## Structure
- Shared package vga_timing_pkg holds:
  - the default timing constants
  - the derived values H_TOTAL, V_TOTAL, H_START=142, V_START=34
  - image window constants IMAGE_WIDTH, IMAGE_HEIGHT and IMAGE_PIXELS=20480, shared with the RGB stage and the image ROM
- Sub-module vga_axis_counter is instantiated twice, once for horizontal and once for vertical. Its interface:
  - parameters: SYNC, BP, ACTIVE, FP
  - inputs: enable, clear
  - outputs: count, sync_n, active, wrap

## Test plan
- Reset, then i_on=1 for 2 frames:
  - o_hcnt cycles 0..799
  - o_vcnt cycles 0..524
  - o_frame_start pulses every 420000 cycles
  - hsync is low for 96 cycles per line; vsync is low for 2 lines (1600 cycles)
- Count o_blank=1 cycles per frame: exactly 307200. The first is at (142,34) and the last at (781,513).
- Count o_image_active=1 cycles per frame: exactly 20480. The first is at (398,194) and the last at (525,353).
- Update handshake:
  - Pulse i_update_req at (0,100), then again at (200,300): a single o_new_data pulse at (0,514).
  - Pulse at (0,514): o_new_data at (0,514), and no second pulse in the next frame.
- i_on toggles:
  - Drop i_on at (500,200): counters read 0,0, syncs 1, flags 0 next cycle.
  - Raise i_on: counting restarts at 0,0 with o_frame_start=1.
- Assert i_arst asynchronously mid-line: all outputs reach their reset values before the next clock edge. After release, behaviour matches a fresh start.
